register_to_uart: RTL and testbench

//  Write-back-side output path: on an out-instruction, captures reg_data[7:0] into a small FIFO and drains it to the UART transmitter.

---
 rtl/register_to_uart_if.sv | 21 ++
 rtl/register_to_uart.sv | 161 ++++++++++++++++
 tb/tb_register_to_uart.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/register_to_uart_if.sv
// Byte handshake between the output write-back stage and the UART TX core.
// The master side launches a byte with a one-cycle tx_start while tx_ready is high.
interface register_to_uart_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_start;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_ready
    );
endinterface

// File: rtl/register_to_uart.sv
// Write-back output path: queues the low byte of reg_data on each rising edge of
// RegtoUART and drains the queue to the UART TX core, stalling the PC only when full.
module register_to_uart #(
    parameter int FIFO_DEPTH_LOG = 2,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      RegtoUART,
    input  logic [31:0]               reg_data,
    register_to_uart_if.master        tx,
    output logic                      pc_enable,
    output logic [FIFO_DEPTH_LOG:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam logic [FIFO_DEPTH_LOG:0] DEPTH_CNT = {1'b1, {FIFO_DEPTH_LOG{1'b0}}};

    localparam logic [0:0] IN_RUN    = 1'b0;
    localparam logic [0:0] IN_STALL  = 1'b1;
    localparam logic [0:0] OUT_IDLE  = 1'b0;
    localparam logic [0:0] OUT_GUARD = 1'b1;

    logic                      req_buf;
    logic                      req;
    logic [0:0]                in_state;
    logic [0:0]                out_state;
    logic [DATA_WIDTH-1:0]     pending;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG:0]   count;
    logic                      full;
    logic                      pop;
    logic                      push;
    logic [DATA_WIDTH-1:0]     push_data;
    logic                      unused_hi_bits;

    assign unused_hi_bits = ^reg_data[31:DATA_WIDTH];

    assign req        = RegtoUART && !req_buf;
    assign full       = (count == DEPTH_CNT);
    assign pop        = (out_state == OUT_IDLE) && (count != '0) && tx.tx_ready;
    assign fifo_count = count;

    // A pop in the same cycle frees the slot the push needs, so full only blocks without one.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        push      = 1'b0;
        push_data = reg_data[DATA_WIDTH-1:0];
        case (in_state)
            IN_RUN: begin
                if (req && (!full || pop)) begin
                    push = 1'b1;
                end
            end
            IN_STALL: begin
                if (!full || pop) begin
                    push      = 1'b1;
                    push_data = pending;
                end
            end
            default: begin
                push = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            req_buf <= 1'b0;
        end else begin
            req_buf <= RegtoUART;
        end
    end

    // Input FSM: holds one byte aside while the FIFO is full and the PC is frozen.
    always_ff @(posedge CLK) begin
        if (reset) begin
            in_state  <= IN_RUN;
            pending   <= '0;
            pc_enable <= 1'b1;
        end else begin
            case (in_state)
                IN_RUN: begin
                    if (req && full && !pop) begin
                        pending   <= reg_data[DATA_WIDTH-1:0];
                        pc_enable <= 1'b0;
                        in_state  <= IN_STALL;
                    end
                end
                IN_STALL: begin
                    if (!full || pop) begin
                        pc_enable <= 1'b1;
                        in_state  <= IN_RUN;
                    end
                end
                default: begin
                    in_state <= IN_RUN;
                end
            endcase
        end
    end

    // Output FSM: the GUARD cycle keeps tx_start one cycle wide and never back-to-back.
    always_ff @(posedge CLK) begin
        if (reset) begin
            out_state   <= OUT_IDLE;
            tx.tx_data  <= '0;
            tx.tx_start <= 1'b0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (pop) begin
                        tx.tx_data  <= mem[rd_ptr];
                        tx.tx_start <= 1'b1;
                        out_state   <= OUT_GUARD;
                    end
                end
                OUT_GUARD: begin
                    tx.tx_start <= 1'b0;
                    out_state   <= OUT_IDLE;
                end
                default: begin
                    tx.tx_start <= 1'b0;
                    out_state   <= OUT_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full, wr_ptr equals rd_ptr: the head is read out at the same edge it is overwritten.
    always_ff @(posedge CLK) begin
        // NOTE: storage is left unreset; the pointers and count alone define which entries are valid.
        if (push && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_register_to_uart.sv
// Directed bench for register_to_uart: a per-cycle vector table for fill/stall/drain
// plus hand-written sequences for latency, level hold, full-with-pop, wrap and reset.
module tb_register_to_uart;

    logic        CLK = 1'b0;
    logic        reset;
    logic        RegtoUART;
    logic [31:0] reg_data;
    logic        tx_ready;
    logic        pc_enable;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx [$];

    register_to_uart_if #(.DATA_WIDTH(8)) tx_if ();
    assign tx_if.tx_ready = tx_ready;

    register_to_uart #(
        .FIFO_DEPTH_LOG(2),
        .DATA_WIDTH(8)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .RegtoUART(RegtoUART),
        .reg_data(reg_data),
        .tx(tx_if.master),
        .pc_enable(pc_enable),
        .fifo_count(fifo_count)
    );

    always #5 CLK = ~CLK;

    // Byte receiver: records every launched byte mid-cycle.
    always @(negedge CLK) begin
        if (tx_if.tx_start === 1'b1) begin
            rx.push_back(tx_if.tx_data);
        end
    end

    typedef struct {
        logic        r;
        logic [31:0] d;
        logic        rdy;
        logic        exp_pc;
        logic [2:0]  exp_cnt;
        logic        exp_start;
        logic        chk_data;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cycle(input logic r, input logic [31:0] d, input logic rdy);
        RegtoUART = r;
        reg_data  = d;
        tx_ready  = rdy;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic rdy);
        cycle(1'b1, d, rdy);
        cycle(1'b0, d, rdy);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 64 && fifo_count != 3'd0; n++) begin
            cycle(1'b0, 32'h0, 1'b1);
        end
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check({name, " drained count"}, 32'(fifo_count), 32'd0);
    endtask

    task automatic check_rx(input string name, input int first, input int num);
        check({name, " rx size"}, 32'(rx.size()), 32'(num));
        for (int i = 0; i < num; i++) begin
            check({name, " rx byte"}, (i < rx.size()) ? 32'(rx[i]) : 32'hFFFF_FFFF, 32'(first + i));
        end
    endtask

    initial begin
        logic       rdy_t;
        logic [2:0] peak;

        // Fill to 4, stall on byte 5, then drain; upper reg_data bits are garbage.
        vecs[0]  = '{1'b1, 32'hDEAD_BE01, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 32'hDEAD_BE01, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 32'hDEAD_BE02, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 32'hDEAD_BE02, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 32'hDEAD_BE03, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 32'hDEAD_BE03, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 32'hDEAD_BE04, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 32'hDEAD_BE04, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 32'hDEAD_BE05, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 8'h01};
        vecs[11] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 8'h01};
        vecs[12] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 8'h02};
        vecs[13] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 8'h02};
        vecs[14] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 8'h03};
        vecs[15] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 8'h03};
        vecs[16] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 8'h04};
        vecs[17] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 8'h04};
        vecs[18] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 8'h05};
        vecs[19] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 8'h05};

        // Reset state
        reset = 1'b1;
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check("reset tx_start",   32'(tx_if.tx_start), 32'd0);
        check("reset tx_data",    32'(tx_if.tx_data),  32'd0);
        check("reset pc_enable",  32'(pc_enable),      32'd1);
        check("reset fifo_count", 32'(fifo_count),     32'd0);
        reset = 1'b0;
        cycle(1'b0, 32'h0, 1'b1);

        // Single send: request cycle N, tx_start in N+2 only
        cycle(1'b1, 32'h0000_0141, 1'b1);
        check("single N+1 start", 32'(tx_if.tx_start), 32'd0);
        check("single N+1 count", 32'(fifo_count),     32'd1);
        cycle(1'b1, 32'h0000_0141, 1'b1);
        check("single N+2 start", 32'(tx_if.tx_start), 32'd1);
        check("single N+2 data",  32'(tx_if.tx_data),  32'h41);
        check("single N+2 count", 32'(fifo_count),     32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        check("single N+3 start", 32'(tx_if.tx_start), 32'd0);
        check("single hold data", 32'(tx_if.tx_data),  32'h41);
        check("single pc_enable", 32'(pc_enable),      32'd1);

        // Level hold: ten cycles high give one entry
        peak = 3'd0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h0000_0055, 1'b0);
            if (fifo_count > peak) peak = fifo_count;
        end
        check("level peak count", 32'(peak), 32'd1);
        cycle(1'b0, 32'h0, 1'b1);
        check("level pop start", 32'(tx_if.tx_start), 32'd1);
        check("level pop data",  32'(tx_if.tx_data),  32'h55);
        check("level pop count", 32'(fifo_count),     32'd0);
        cycle(1'b0, 32'h0, 1'b0);

        // Fill, stall, drain
        rx.delete();
        for (int i = 0; i < 20; i++) begin
            cycle(vecs[i].r, vecs[i].d, vecs[i].rdy);
            check($sformatf("vec%0d pc_enable", i), 32'(pc_enable),      32'(vecs[i].exp_pc));
            check($sformatf("vec%0d count", i),     32'(fifo_count),     32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d tx_start", i),  32'(tx_if.tx_start), 32'(vecs[i].exp_start));
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d tx_data", i), 32'(tx_if.tx_data), 32'(vecs[i].exp_data));
            end
        end
        check_rx("fill", 1, 5);

        // Full with a simultaneous pop: push accepted, no stall
        rx.delete();
        for (int i = 0; i < 4; i++) begin
            send(32'h0000_00A0 + 32'(i), 1'b0);
        end
        check("fullpop pre count", 32'(fifo_count), 32'd4);
        cycle(1'b1, 32'h0000_00A4, 1'b1);
        check("fullpop count",     32'(fifo_count),     32'd4);
        check("fullpop pc_enable", 32'(pc_enable),      32'd1);
        check("fullpop tx_start",  32'(tx_if.tx_start), 32'd1);
        cycle(1'b0, 32'h0, 1'b1);
        check("fullpop pc later",  32'(pc_enable),      32'd1);
        drain("fullpop");
        check_rx("fullpop", 32'hA0, 5);

        // Pointer wrap with tx_ready toggling every cycle
        rx.delete();
        rdy_t = 1'b0;
        for (int i = 0; i < 9; i++) begin
            for (int n = 0; n < 32 && !pc_enable; n++) begin
                cycle(1'b0, 32'h0, rdy_t);
                rdy_t = ~rdy_t;
            end
            cycle(1'b1, 32'h0000_0010 + 32'(i), rdy_t);
            rdy_t = ~rdy_t;
            cycle(1'b0, 32'h0, rdy_t);
            rdy_t = ~rdy_t;
        end
        drain("wrap");
        check_rx("wrap", 32'h10, 9);

        // Reset while stalled discards queue and pending byte
        rx.delete();
        for (int i = 0; i < 5; i++) begin
            send(32'h0000_0020 + 32'(i), 1'b0);
        end
        check("stall pc_enable", 32'(pc_enable),  32'd0);
        check("stall count",     32'(fifo_count), 32'd4);
        reset = 1'b1;
        cycle(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        check("rst pc_enable", 32'(pc_enable),      32'd1);
        check("rst count",     32'(fifo_count),     32'd0);
        check("rst tx_start",  32'(tx_if.tx_start), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
        end
        check("rst nothing sent", 32'(rx.size()),  32'd0);
        check("rst count after",  32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
